// File: rtl/pe_stage_sched.sv
// pe_stage_sched: sequences one SC-decoder F/G node update over a time-multiplexed PE array
module pe_stage_sched #(
  parameter int P_NUM   = 8,
  parameter int ADDR_W  = 8,
  parameter int LOG_W   = 4,
  parameter int LOG_MAX = 10,
  parameter int RD_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op,
  input  logic [LOG_W-1:0]  log_len,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W-1:0] wr_base,
  input  logic [ADDR_W-1:0] ps_base,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr0,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic              ps_rd_en,
  output logic [ADDR_W-1:0] ps_rd_addr,
  output logic              pe_op,
  output logic              pe_valid,
  output logic [P_NUM-1:0]  lane_mask,
  output logic [LOG_W-1:0]  sub_log,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  localparam logic [LOG_W-1:0] LP   = LOG_W'($clog2(P_NUM));
  localparam logic [LOG_W-1:0] LMAX = LOG_W'(LOG_MAX);
  state_t state;
  logic [ADDR_W-1:0] b, last_b, off1, rd_base_r, wr_base_r, ps_base_r, beats;
  logic [LOG_W-1:0]  len_sat;
  logic [P_NUM-1:0]  mask_n;
  logic [RD_LAT-1:0] vld, vld_nx;
  logic [ADDR_W-1:0] tag [RD_LAT];
  always_comb begin
    len_sat = log_len > LMAX ? LMAX : log_len;
    beats   = len_sat >= LP ? ADDR_W'(1) << (len_sat - LP) : ADDR_W'(1);
    mask_n  = len_sat >= LP ? '1 : P_NUM'((1 << (1 << len_sat)) - 1);
    rd_en   = state == ISSUE && !hold;
    vld_nx  = (vld << 1) | RD_LAT'(rd_en);
  end
  assign busy       = state != IDLE;
  assign done       = state == DONE;
  assign rd_addr0   = rd_base_r + b;
  assign rd_addr1   = rd_base_r + off1 + b;
  assign ps_rd_en   = rd_en & pe_op;
  assign ps_rd_addr = ps_base_r + b;
  assign pe_valid   = vld[RD_LAT-1];
  assign wr_en      = vld[RD_LAT-1];
  assign wr_addr    = wr_base_r + tag[RD_LAT-1];
  // the beat index travels alongside each read so bubbles from hold keep write order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      b         <= '0;
      last_b    <= '0;
      off1      <= '0;
      rd_base_r <= '0;
      wr_base_r <= '0;
      ps_base_r <= '0;
      vld       <= '0;
      for (int i = 0; i < RD_LAT; i++) tag[i] <= '0;
      pe_op     <= 1'b0;
      sub_log   <= '0;
      lane_mask <= '0;
    end else begin
      vld    <= vld_nx;
      tag[0] <= b;
      for (int i = 1; i < RD_LAT; i++) tag[i] <= tag[i-1];
      case (state)
        IDLE: if (start) begin
          state     <= ISSUE;
          b         <= '0;
          last_b    <= beats - ADDR_W'(1);
          off1      <= beats != ADDR_W'(1) ? beats : '0;
          rd_base_r <= rd_base;
          wr_base_r <= wr_base;
          ps_base_r <= ps_base;
          pe_op     <= op;
          sub_log   <= len_sat;
          lane_mask <= mask_n;
        end
        ISSUE: if (!hold) begin
          if (b == last_b) state <= DRAIN;
          else b <= b + ADDR_W'(1);
        end
        DRAIN: if (vld_nx == '0) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_stage_sched.sv
// tb_pe_stage_sched: vector table plus write-address scoreboard for pe_stage_sched
module tb_pe_stage_sched;
  logic clk = 0, rst_n = 0, start = 0, op = 0, hold = 0;
  logic [3:0] log_len = 0;
  logic [7:0] rd_base = 0, wr_base = 0, ps_base = 0;
  logic busy, done, rd_en, ps_rd_en, pe_op, pe_valid, wr_en;
  logic [7:0] rd_addr0, rd_addr1, ps_rd_addr, wr_addr, lane_mask;
  logic [3:0] sub_log;
  int checks = 0, errors = 0;
  logic [7:0] sb [$];

  typedef struct {
    logic       op;
    logic [3:0] len;
    logic [7:0] rb, wb, pb, hm;
    int         b;
    logic [7:0] mask;
    logic [3:0] sl;
    int         lat;
  } vec_t;
  vec_t vt [7];

  pe_stage_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .log_len(log_len),
    .rd_base(rd_base), .wr_base(wr_base), .ps_base(ps_base), .hold(hold),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .ps_rd_en(ps_rd_en), .ps_rd_addr(ps_rd_addr), .pe_op(pe_op), .pe_valid(pe_valid),
    .lane_mask(lane_mask), .sub_log(sub_log), .wr_en(wr_en), .wr_addr(wr_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_done"}, 32'(done), 0);
    chk({nm, "_rd_en"}, 32'(rd_en), 0);
    chk({nm, "_ps_rd_en"}, 32'(ps_rd_en), 0);
    chk({nm, "_wr_en"}, 32'(wr_en), 0);
    chk({nm, "_pe_valid"}, 32'(pe_valid), 0);
    chk({nm, "_rd_addr0"}, 32'(rd_addr0), 0);
    chk({nm, "_rd_addr1"}, 32'(rd_addr1), 0);
    chk({nm, "_ps_rd_addr"}, 32'(ps_rd_addr), 0);
    chk({nm, "_wr_addr"}, 32'(wr_addr), 0);
    chk({nm, "_lane_mask"}, 32'(lane_mask), 0);
    chk({nm, "_sub_log"}, 32'(sub_log), 0);
    chk({nm, "_pe_op"}, 32'(pe_op), 0);
  endtask

  task automatic run_op(input vec_t v);
    int issued = 0, k = 0, wrote = 0;
    logic rd_prev = 0, exp_rd, issuing;
    sb.delete();
    tick();
    start = 1; op = v.op; log_len = v.len; rd_base = v.rb; wr_base = v.wb; ps_base = v.pb; hold = 0;
    #1;
    chk("idle_before_start", 32'(busy), 0);
    for (int n = 1; n <= v.lat; n++) begin
      tick();
      start = 0;
      issuing = issued < v.b;
      hold = (issuing && k < 8) ? v.hm[k] : 1'b0;
      #1;
      exp_rd = issuing && !hold;
      chk("busy", 32'(busy), 1);
      chk("rd_en", 32'(rd_en), 32'(exp_rd));
      chk("ps_rd_en", 32'(ps_rd_en), 32'(exp_rd & v.op));
      chk("wr_en", 32'(wr_en), 32'(rd_prev));
      chk("done", 32'(done), 32'(n == v.lat));
      if (n == 1) begin
        chk("lane_mask", 32'(lane_mask), 32'(v.mask));
        chk("sub_log", 32'(sub_log), 32'(v.sl));
        chk("pe_op", 32'(pe_op), 32'(v.op));
      end
      if (exp_rd) begin
        chk("rd_addr0", 32'(rd_addr0), 32'(8'(v.rb + issued)));
        chk("rd_addr1", 32'(rd_addr1), 32'(8'(v.rb + (v.b > 1 ? v.b : 0) + issued)));
        if (v.op) chk("ps_rd_addr", 32'(ps_rd_addr), 32'(8'(v.pb + issued)));
        sb.push_back(8'(v.wb + issued));
        issued++;
      end
      if (wr_en) begin
        wrote++;
        if (sb.size() == 0) chk("wr_unexpected", 32'(wr_addr), 32'hFFFF_FFFF);
        else chk("wr_addr", 32'(wr_addr), 32'(sb.pop_front()));
      end
      if (issuing) k++;
      rd_prev = exp_rd;
    end
    hold = 0;
    chk("write_count", wrote, v.b);
    chk("sb_empty", sb.size(), 0);
    tick();
    #1;
    chk("busy_after", 32'(busy), 0);
    chk("done_after", 32'(done), 0);
  endtask

  initial begin
    vt[0] = '{1'b0, 4'd5,  8'h10, 8'h40, 8'h00, 8'h00, 4,   8'hFF, 4'd5,  6};
    vt[1] = '{1'b1, 4'd2,  8'h30, 8'h50, 8'h20, 8'h00, 1,   8'h0F, 4'd2,  3};
    vt[2] = '{1'b0, 4'd4,  8'h10, 8'h40, 8'h00, 8'h06, 2,   8'hFF, 4'd4,  6};
    vt[3] = '{1'b1, 4'd6,  8'hFE, 8'hFE, 8'hFE, 8'h00, 8,   8'hFF, 4'd6,  10};
    vt[4] = '{1'b0, 4'd0,  8'h05, 8'h06, 8'h07, 8'h00, 1,   8'h01, 4'd0,  3};
    vt[5] = '{1'b1, 4'd15, 8'h00, 8'h80, 8'h00, 8'h00, 128, 8'hFF, 4'd10, 130};
    vt[6] = '{1'b0, 4'd10, 8'h33, 8'hC0, 8'h44, 8'hA5, 128, 8'hFF, 4'd10, 134};
    repeat (2) @(posedge clk);
    #2;
    chk_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 7; i++) run_op(vt[i]);

    // start held through busy and DONE is ignored; the idle cycle after DONE accepts it
    tick();
    start = 1; op = 0; log_len = 4; rd_base = 8'h60; wr_base = 8'h70; ps_base = 0; hold = 0;
    #1;
    for (int n = 1; n <= 5; n++) begin
      tick();
      start = 1; log_len = 5; rd_base = 8'h90; wr_base = 8'hA0;
      #1;
      if (n == 1) chk("ign_rd0_a", 32'(rd_addr0), 32'h60);
      if (n == 2) chk("ign_rd0_b", 32'(rd_addr0), 32'h61);
      if (n == 3) chk("ign_wr", 32'(wr_addr), 32'h71);
      chk("ign_busy", 32'(busy), 32'(n <= 4));
      chk("ign_done", 32'(done), 32'(n == 4));
    end
    for (int n = 6; n <= 11; n++) begin
      tick();
      start = 0;
      #1;
      if (n == 6) begin
        chk("acc_rd0", 32'(rd_addr0), 32'h90);
        chk("acc_sub_log", 32'(sub_log), 5);
      end
      chk("acc_busy", 32'(busy), 1);
      chk("acc_done", 32'(done), 32'(n == 11));
    end
    tick();
    #1;
    chk("acc_idle", 32'(busy), 0);

    // asynchronous reset in the middle of issue
    tick();
    start = 1; op = 1; log_len = 5; rd_base = 8'h22; wr_base = 8'h33; ps_base = 8'h44;
    #1;
    tick();
    start = 0;
    #1;
    chk("rst_pre_rd_en", 32'(rd_en), 1);
    tick();
    rst_n = 0;
    #1;
    chk_all_zero("midrst");
    repeat (3) begin
      tick();
      #1;
      chk("midrst_done", 32'(done), 0);
      chk("midrst_busy", 32'(busy), 0);
    end
    tick();
    rst_n = 1;
    run_op(vt[1]);
    run_op(vt[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
